serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial adder stage that wraps one FULL_ADDER_1_BIT instance and feeds it one operand bit pair per clock, LSB first. A registered carry feeds the adder's i_LOWER_CARRY input, and the adder's o_FULL_CARRY output returns to that register each cycle. The block sits directly upstream of the 1-bit full adder in the ALU, sequencing it to produce a WIDTH-bit result with carry and signed-overflow flags. It trades latency for area against the ripple-carry path.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
i_CLK  input  1  rising-edge clock
i_RST_N  input  1  asynchronous active-low reset
i_START  input  1  request a new operation; sampled only in IDLE
i_OPERAND_A  input  WIDTH  operand A; captured on the accepted start edge
i_OPERAND_B  input  WIDTH  operand B; captured on the accepted start edge
i_CARRY_IN  input  1  carry into bit 0; captured on the accepted start edge
i_SUB  input  1  subtract select; captured on the accepted start edge (see Optional Feature)
o_BUSY  output  1  high while bits are being processed
o_DONE  output  1  one-cycle pulse when the result is valid
o_SUM  output  WIDTH  result; holds its value until the next completion
o_CARRY_OUT  output  1  carry out of the MSB
o_OVERFLOW  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- One clock (i_CLK). Reset is asynchronous and active-low (i_RST_N).
- While i_RST_N=0: state=IDLE, all internal registers=0, o_BUSY=0, o_DONE=0, o_SUM=0, o_CARRY_OUT=0, o_OVERFLOW=0.
- FSM has two states, IDLE and SHIFT.
- IDLE, i_START=1 at edge E0:
  - Load the A and B shift registers and the carry register (carry <= i_CARRY_IN).
  - Clear the bit counter.
  - Go to SHIFT. o_BUSY=1 from the cycle after E0.
- SHIFT, each edge:
  - Shift the adder's o_FULL_SUM into the MSB of the internal sum shift register.
  - carry <= o_FULL_CARRY.
  - Shift A and B right by one.
  - Counter increments by 1.
  - The adder sees A[0], B[0], and the carry register combinationally.
- Last bit (counter==WIDTH-1) at edge E_WIDTH:
  - o_SUM <= final sum vector.
  - o_CARRY_OUT <= o_FULL_CARRY.
  - o_OVERFLOW <= carry register XOR o_FULL_CARRY.
  - o_DONE=1 for exactly one cycle; o_BUSY=0; state=IDLE.
- Latency: the start edge is E0; o_DONE and valid outputs are visible in the cycle after edge E_WIDTH (WIDTH clocks after start).
- i_START while BUSY is ignored. Operands and outputs are unaffected and no error is flagged.
- i_START in the o_DONE cycle is accepted (state is IDLE), so back-to-back operations run with no bubble.
- o_SUM, o_CARRY_OUT and o_OVERFLOW update only at completion. They are stable during a subsequent operation.
- Counter is $clog2(WIDTH) bits wide. No wrap occurs because the counter leaves SHIFT at WIDTH-1.
- Reset asserted mid-operation aborts immediately and all outputs clear. No o_DONE pulse is produced after release.
- Input changes on i_OPERAND_A, i_OPERAND_B, i_CARRY_IN and i_SUB after the start edge have no effect.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined: when i_SUB=1 is captured at start, B is loaded bitwise-inverted and carry is forced to 1, ignoring i_CARRY_IN. The result is A-B. o_CARRY_OUT=1 means no borrow. o_OVERFLOW is signed subtraction overflow.
- Not defined: i_SUB port still exists but is ignored, and the block is add-only. No inverter logic is synthesised.

Test Plan:
- WIDTH=8, reset low for 2 cycles, then high -> all outputs 0; o_BUSY=0; 20 idle cycles with i_START=0 produce no o_DONE.
- A=0x0F, B=0x01, CIN=0, START for 1 cycle -> o_BUSY high for 8 cycles, then single o_DONE; o_SUM=0x10, C=0, V=0.
- A=0xFF, B=0x01, CIN=0 -> o_SUM=0x00, C=1, V=0. Then, in the o_DONE cycle, start A=0x7F, B=0x01 -> 8 cycles later o_SUM=0x80, C=0, V=1, with no bubble between the two operations.
- Start A=0x11, B=0x22, CIN=1; pulse i_START again with A=0xFF at bit 3 -> result 0x34, C=0, V=0; second start ignored, single o_DONE.
- Start A=0xAA, B=0x55; assert i_RST_N=0 at bit 4 for 1 cycle -> outputs immediately 0, o_BUSY=0, no o_DONE afterwards; next normal operation correct.
- With SERIAL_ADDER_SUB_EN: A=0x05, B=0x07, SUB=1 -> o_SUM=0xFE, C=0, V=0. A=0x80, B=0x01, SUB=1 -> o_SUM=0x7F, C=1, V=1. Without macro, the same stimulus gives 0x0C and 0x81 respectively.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder that sequences one FULL_ADDER_1_BIT, LSB first.
// Optional macro SERIAL_ADDER_SUB_EN enables A-B through i_SUB (B inverted, carry-in forced to 1).
`default_nettype none

module FULL_ADDER_1_BIT (
  input  logic i_BIT_A,
  input  logic i_BIT_B,
  input  logic i_LOWER_CARRY,
  output logic o_FULL_SUM,
  output logic o_FULL_CARRY
);
  assign o_FULL_SUM   = i_BIT_A ^ i_BIT_B ^ i_LOWER_CARRY;
  assign o_FULL_CARRY = (i_BIT_A & i_BIT_B) | (i_LOWER_CARRY & (i_BIT_A ^ i_BIT_B));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_START,
  input  logic [WIDTH-1:0] i_OPERAND_A,
  input  logic [WIDTH-1:0] i_OPERAND_B,
  input  logic             i_CARRY_IN,
  input  logic             i_SUB,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic [WIDTH-1:0] o_SUM,
  output logic             o_CARRY_OUT,
  output logic             o_OVERFLOW
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-2:0]   sum_sh_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;

  logic               w_full_sum;
  logic               w_full_carry;
  logic [WIDTH-1:0]   w_sum_next;
  logic [WIDTH-1:0]   w_b_load;
  logic               w_carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load     = i_SUB ? ~i_OPERAND_B : i_OPERAND_B;
  assign w_carry_load = i_SUB ? 1'b1 : i_CARRY_IN;
`else
  logic w_unused_sub;
  assign w_unused_sub = i_SUB;
  assign w_b_load     = i_OPERAND_B;
  assign w_carry_load = i_CARRY_IN;
`endif

  FULL_ADDER_1_BIT u_fa (
    .i_BIT_A       (a_q[0]),
    .i_BIT_B       (b_q[0]),
    .i_LOWER_CARRY (carry_q),
    .o_FULL_SUM    (w_full_sum),
    .o_FULL_CARRY  (w_full_carry)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 has reached position 0.
  assign w_sum_next = {w_full_sum, sum_sh_q};

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_START) begin
            a_q     <= i_OPERAND_A;
            b_q     <= w_b_load;
            carry_q <= w_carry_load;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sum_sh_q <= w_sum_next[WIDTH-1:1];
          carry_q  <= w_full_carry;
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            sum_q   <= w_sum_next;
            cout_q  <= w_full_carry;
            // carry_q holds the carry into the MSB at this point
            ovf_q   <= carry_q ^ w_full_carry;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_BUSY      = busy_q;
  assign o_DONE      = done_q;
  assign o_SUM       = sum_q;
  assign o_CARRY_OUT = cout_q;
  assign o_OVERFLOW  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and randomized checks of serial_adder_ctrl against an arithmetic model.
`default_nettype none

module tb_serial_adder_ctrl;

  localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         i_CLK = 1'b0;
  logic         i_RST_N = 1'b0;
  logic         i_START = 1'b0;
  logic [W-1:0] i_OPERAND_A = '0;
  logic [W-1:0] i_OPERAND_B = '0;
  logic         i_CARRY_IN = 1'b0;
  logic         i_SUB = 1'b0;
  logic         o_BUSY;
  logic         o_DONE;
  logic [W-1:0] o_SUM;
  logic         o_CARRY_OUT;
  logic         o_OVERFLOW;

  int n_vec = 0;
  int n_err = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .i_CLK       (i_CLK),
    .i_RST_N     (i_RST_N),
    .i_START     (i_START),
    .i_OPERAND_A (i_OPERAND_A),
    .i_OPERAND_B (i_OPERAND_B),
    .i_CARRY_IN  (i_CARRY_IN),
    .i_SUB       (i_SUB),
    .o_BUSY      (o_BUSY),
    .o_DONE      (o_DONE),
    .o_SUM       (o_SUM),
    .o_CARRY_OUT (o_CARRY_OUT),
    .o_OVERFLOW  (o_OVERFLOW)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, carry_out, sum} from plain arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bo;
    logic         ci;
    logic [W:0]   full;
    logic         v;
    bo = b;
    ci = cin;
    if (sub && SUB_EN) begin
      bo = ~b;
      ci = 1'b1;
    end
    full = {1'b0, a} + {1'b0, bo} + {{W{1'b0}}, ci};
    v = (a[W-1] == bo[W-1]) && (full[W-1] != a[W-1]);
    return {v, full};
  endfunction

  task automatic scramble_inputs();
    i_OPERAND_A = W'($urandom);
    i_OPERAND_B = W'($urandom);
    i_CARRY_IN  = 1'($urandom);
    i_SUB       = 1'($urandom);
  endtask

  // Called at posedge+1: presents operands with i_START for the next edge (E0).
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    i_OPERAND_A = a;
    i_OPERAND_B = b;
    i_CARRY_IN  = cin;
    i_SUB       = sub;
    i_START     = 1'b1;
  endtask

  // Runs through E0..E_W; optionally re-pulses i_START with junk at bit glitch_at.
  task automatic finish_op(input int glitch_at, input logic [W-1:0] es,
                           input logic ec, input logic ev);
    int           busy_cnt;
    int           done_cnt;
    logic         stable;
    logic [W-1:0] prev_sum;
    @(posedge i_CLK); #1;
    prev_sum = o_SUM;
    busy_cnt = 0;
    done_cnt = 0;
    stable   = 1'b1;
    for (int k = 0; k < W; k++) begin
      if (o_BUSY) busy_cnt++;
      if (o_DONE) done_cnt++;
      if (o_SUM !== prev_sum) stable = 1'b0;
      scramble_inputs();
      i_START = (k == glitch_at);
      @(posedge i_CLK); #1;
    end
    i_START = 1'b0;
    check("busy_cycles", busy_cnt, W);
    check("early_done", done_cnt, 0);
    check("sum_stable", {31'd0, stable}, 1);
    check("done", {31'd0, o_DONE}, 1);
    check("busy_at_done", {31'd0, o_BUSY}, 0);
    check("sum", {24'd0, o_SUM}, {24'd0, es});
    check("carry", {31'd0, o_CARRY_OUT}, {31'd0, ec});
    check("ovf", {31'd0, o_OVERFLOW}, {31'd0, ev});
  endtask

  task automatic post_check(input logic [W-1:0] es);
    @(posedge i_CLK); #1;
    check("done_single", {31'd0, o_DONE}, 0);
    check("sum_hold", {24'd0, o_SUM}, {24'd0, es});
  endtask

  initial begin
    logic [W+1:0] exp;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           idle_done;
    int           after_rst;

    // Reset and idle
    repeat (2) @(posedge i_CLK);
    #1;
    check("rst_busy", {31'd0, o_BUSY}, 0);
    check("rst_done", {31'd0, o_DONE}, 0);
    check("rst_sum", {24'd0, o_SUM}, 0);
    check("rst_cv", {30'd0, o_CARRY_OUT, o_OVERFLOW}, 0);
    i_RST_N = 1'b1;
    idle_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge i_CLK); #1;
      if (o_DONE || o_BUSY) idle_done++;
    end
    check("idle_activity", idle_done, 0);

    start_op(8'h0F, 8'h01, 1'b0, 1'b0);
    finish_op(-1, 8'h10, 1'b0, 1'b0);
    post_check(8'h10);

    // Back-to-back: second start issued in the done cycle
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    finish_op(-1, 8'h00, 1'b1, 1'b0);
    start_op(8'h7F, 8'h01, 1'b0, 1'b0);
    finish_op(-1, 8'h80, 1'b0, 1'b1);
    post_check(8'h80);

    // Start while busy is ignored
    start_op(8'h11, 8'h22, 1'b1, 1'b0);
    finish_op(3, 8'h34, 1'b0, 1'b0);
    post_check(8'h34);

    // Mid-operation reset
    start_op(8'hAA, 8'h55, 1'b0, 1'b0);
    @(posedge i_CLK); #1;
    i_START = 1'b0;
    repeat (4) @(posedge i_CLK);
    #1;
    i_RST_N = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, o_BUSY}, 0);
    check("mid_rst_done", {31'd0, o_DONE}, 0);
    check("mid_rst_sum", {24'd0, o_SUM}, 0);
    check("mid_rst_cv", {30'd0, o_CARRY_OUT, o_OVERFLOW}, 0);
    @(posedge i_CLK); #1;
    i_RST_N = 1'b1;
    after_rst = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge i_CLK); #1;
      if (o_DONE || o_BUSY) after_rst++;
    end
    check("post_rst_activity", after_rst, 0);
    start_op(8'h3C, 8'h0F, 1'b0, 1'b0);
    finish_op(-1, 8'h4B, 1'b0, 1'b0);
    post_check(8'h4B);

    // Subtract select (ignored in add-only build)
    start_op(8'h05, 8'h07, 1'b0, 1'b1);
    if (SUB_EN) finish_op(-1, 8'hFE, 1'b0, 1'b0);
    else        finish_op(-1, 8'h0C, 1'b0, 1'b0);
    start_op(8'h80, 8'h01, 1'b0, 1'b1);
    if (SUB_EN) finish_op(-1, 8'h7F, 1'b1, 1'b1);
    else        finish_op(-1, 8'h81, 1'b0, 1'b0);
    @(posedge i_CLK); #1;

    // Randomized operations against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (n % 8 == 0) ra = '1;
      if (n % 8 == 1) rb = {1'b1, {(W-1){1'b0}}};
      exp = model(ra, rb, rc, rs);
      start_op(ra, rb, rc, rs);
      finish_op(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 2)) : -1,
                exp[W-1:0], exp[W], exp[W+1]);
      if ($urandom_range(0, 1) == 0) post_check(exp[W-1:0]);
    end
    @(posedge i_CLK); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
